// File: rtl/game_pkg.sv
// Shared game definitions: direction encoding and the mover state encoding,
// used by both the character movers and the mouse AI.
package game_pkg;

    localparam logic [1:0] DIR_RIGHT = 2'd0;
    localparam logic [1:0] DIR_DOWN  = 2'd1;
    localparam logic [1:0] DIR_LEFT  = 2'd2;
    localparam logic [1:0] DIR_UP    = 2'd3;

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_COUNT  = 2'd1,
        ST_QUERY  = 2'd2,
        ST_COMMIT = 2'd3
    } mover_state_e;

endpackage

// File: rtl/tile_step.sv
// Combinational one-tile step: target of pos moved one tile in dir, with an
// off_grid flag instead of wrapping. The target never leaves the grid.
module tile_step
    import game_pkg::*;
#(
    parameter int GRID_W = 32,
    parameter int GRID_H = 24,
    parameter int X_W    = 5,
    parameter int Y_W    = 5
) (
    input  logic [X_W-1:0] pos_x,
    input  logic [Y_W-1:0] pos_y,
    input  logic [1:0]     dir,
    output logic [X_W-1:0] tgt_x,
    output logic [Y_W-1:0] tgt_y,
    output logic           off_grid
);

    always_comb begin
        // NOTE: every output gets a default before the case, so no path infers a latch.
        tgt_x    = pos_x;
        tgt_y    = pos_y;
        off_grid = 1'b0;
        case (dir)
            DIR_RIGHT: if (pos_x == X_W'(GRID_W - 1)) off_grid = 1'b1;
                       else                           tgt_x = pos_x + X_W'(1);
            DIR_DOWN:  if (pos_y == Y_W'(GRID_H - 1)) off_grid = 1'b1;
                       else                           tgt_y = pos_y + Y_W'(1);
            DIR_LEFT:  if (pos_x == '0)               off_grid = 1'b1;
                       else                           tgt_x = pos_x - X_W'(1);
            default:   if (pos_y == '0)               off_grid = 1'b1;
                       else                           tgt_y = pos_y - Y_W'(1);
        endcase
    end

endmodule

// File: rtl/character_mover.sv
// Steps one character across the tile grid every STEP_DIV frame ticks, asking
// the maze over a valid/ack handshake whether the target tile is a wall.
module character_mover
    import game_pkg::*;
#(
    parameter int GRID_W   = 32,
    parameter int GRID_H   = 24,
    parameter int X_W      = 5,
    parameter int Y_W      = 5,
    parameter int START_X  = 0,
    parameter int START_Y  = 0,
    parameter int STEP_DIV = 4
) (
    input  logic           clk,
    input  logic           rst_n,
    input  logic           enable,
    input  logic           move_tick,
    input  logic [1:0]     char_dir,
    input  logic           dir_valid,
    output logic           query_valid,
    output logic [X_W-1:0] query_x,
    output logic [Y_W-1:0] query_y,
    input  logic           query_ack,
    input  logic           query_blocked,
    output logic [X_W-1:0] pos_x,
    output logic [Y_W-1:0] pos_y,
    output logic [1:0]     facing,
    output logic           moved,
    output logic           bump
);

    localparam int CNT_W = (STEP_DIV > 1) ? $clog2(STEP_DIV) : 1;

    mover_state_e     state_q, state_d;
    logic [CNT_W-1:0] tick_cnt_q, tick_cnt_d;
    logic [X_W-1:0]   pos_x_q, pos_x_d, tgt_x_q, tgt_x_d, step_x;
    logic [Y_W-1:0]   pos_y_q, pos_y_d, tgt_y_q, tgt_y_d, step_y;
    logic [1:0]       facing_q, facing_d;
    logic             moved_q, moved_d, bump_q, bump_d;
    logic             off_grid;

    // facing_q is sampled as the step direction on the last tick; the latched
    // target then carries the step, so later dir_valid changes facing only.
    tile_step #(
        .GRID_W(GRID_W), .GRID_H(GRID_H), .X_W(X_W), .Y_W(Y_W)
    ) u_step (
        .pos_x   (pos_x_q),
        .pos_y   (pos_y_q),
        .dir     (facing_q),
        .tgt_x   (step_x),
        .tgt_y   (step_y),
        .off_grid(off_grid)
    );

    always_comb begin
        state_d    = state_q;
        tick_cnt_d = tick_cnt_q;
        pos_x_d    = pos_x_q;
        pos_y_d    = pos_y_q;
        tgt_x_d    = tgt_x_q;
        tgt_y_d    = tgt_y_q;
        facing_d   = dir_valid ? char_dir : facing_q;
        moved_d    = 1'b0;
        bump_d     = 1'b0;
        case (state_q)
            ST_IDLE: begin
                if (enable) begin
                    tick_cnt_d = '0;
                    state_d    = ST_COUNT;
                end
            end
            ST_COUNT: begin
                if (!enable) begin
                    tick_cnt_d = '0;
                    state_d    = ST_IDLE;
                end else if (move_tick) begin
                    if (tick_cnt_q == CNT_W'(STEP_DIV - 1)) begin
                        tick_cnt_d = '0;
                        if (off_grid) begin
                            bump_d = 1'b1;
                        end else begin
                            tgt_x_d = step_x;
                            tgt_y_d = step_y;
                            state_d = ST_QUERY;
                        end
                    end else begin
                        tick_cnt_d = tick_cnt_q + CNT_W'(1);
                    end
                end
            end
            ST_QUERY: begin
                // The commit outcome is registered at the ack edge so that pos
                // and the moved/bump pulse are all visible during COMMIT.
                if (query_ack) begin
                    state_d = ST_COMMIT;
                    if (enable) begin
                        if (query_blocked) begin
                            bump_d = 1'b1;
                        end else begin
                            pos_x_d = tgt_x_q;
                            pos_y_d = tgt_y_q;
                            moved_d = 1'b1;
                        end
                    end
                end
            end
            ST_COMMIT: begin
                tick_cnt_d = '0;
                state_d    = enable ? ST_COUNT : ST_IDLE;
            end
            default: state_d = ST_IDLE;
        endcase
    end

    // NOTE: sequential state uses non-blocking assignments only.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q    <= ST_IDLE;
            tick_cnt_q <= '0;
            pos_x_q    <= X_W'(START_X);
            pos_y_q    <= Y_W'(START_Y);
            tgt_x_q    <= '0;
            tgt_y_q    <= '0;
            facing_q   <= DIR_RIGHT;
            moved_q    <= 1'b0;
            bump_q     <= 1'b0;
        end else begin
            state_q    <= state_d;
            tick_cnt_q <= tick_cnt_d;
            pos_x_q    <= pos_x_d;
            pos_y_q    <= pos_y_d;
            tgt_x_q    <= tgt_x_d;
            tgt_y_q    <= tgt_y_d;
            facing_q   <= facing_d;
            moved_q    <= moved_d;
            bump_q     <= bump_d;
        end
    end

    assign query_valid = (state_q == ST_QUERY);
    assign query_x     = tgt_x_q;
    assign query_y     = tgt_y_q;
    assign pos_x       = pos_x_q;
    assign pos_y       = pos_y_q;
    assign facing      = facing_q;
    assign moved       = moved_q;
    assign bump        = bump_q;

endmodule

// File: tb/tb_character_mover.sv
// Directed bench for character_mover: reset, free moves, walls, grid edges,
// mid-query direction change and mid-query disable.
module tb_character_mover;
    import game_pkg::*;

    logic       clk = 1'b0;
    logic       rst_n, enable, move_tick, dir_valid, query_ack, query_blocked;
    logic [1:0] char_dir;
    logic       query_valid, moved, bump;
    logic [4:0] query_x, query_y, pos_x, pos_y;
    logic [1:0] facing;

    int n_vec = 0;
    int n_err = 0;

    always #5 clk = ~clk;

    character_mover dut (
        .clk          (clk),
        .rst_n        (rst_n),
        .enable       (enable),
        .move_tick    (move_tick),
        .char_dir     (char_dir),
        .dir_valid    (dir_valid),
        .query_valid  (query_valid),
        .query_x      (query_x),
        .query_y      (query_y),
        .query_ack    (query_ack),
        .query_blocked(query_blocked),
        .pos_x        (pos_x),
        .pos_y        (pos_y),
        .facing       (facing),
        .moved        (moved),
        .bump         (bump)
    );

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_vec++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
        end
    endtask

    task automatic load_dir(input logic [1:0] d);
        char_dir  = d;
        dir_valid = 1'b1;
        @(negedge clk);
        dir_valid = 1'b0;
    endtask

    task automatic send_ticks(input int n);
        for (int i = 0; i < n; i++) begin
            move_tick = 1'b1;
            @(negedge clk);
            move_tick = 1'b0;
        end
    endtask

    task automatic wait_query();
        int n = 0;
        while (query_valid !== 1'b1 && n < 20) begin
            @(negedge clk);
            n++;
        end
        check("query_seen", query_valid, 1);
    endtask

    task automatic ack(input logic blk, input int dly);
        for (int i = 0; i < dly; i++) begin
            check("query_held", query_valid, 1);
            @(negedge clk);
        end
        query_ack     = 1'b1;
        query_blocked = blk;
        @(negedge clk);
        query_ack     = 1'b0;
        query_blocked = 1'b0;
    endtask

    task automatic check_commit(input logic exp_moved, input logic exp_bump, input int px, input int py);
        check("commit_moved", moved, exp_moved);
        check("commit_bump", bump, exp_bump);
        check("commit_pos_x", pos_x, px);
        check("commit_pos_y", pos_y, py);
        check("commit_qv_low", query_valid, 0);
        @(negedge clk);
        check("pulse_end", {moved, bump}, 0);
    endtask

    task automatic do_step(input bit set_dir, input logic [1:0] d, input logic blk, input int dly,
                           input int qx, input int qy, input int px, input int py);
        if (set_dir) load_dir(d);
        send_ticks(4);
        wait_query();
        check("query_x", query_x, qx);
        check("query_y", query_y, qy);
        ack(blk, dly);
        check_commit(!blk, blk, px, py);
    endtask

    initial begin
        rst_n = 1'b0; enable = 1'b0; move_tick = 1'b0; dir_valid = 1'b0;
        char_dir = 2'd0; query_ack = 1'b0; query_blocked = 1'b0;
        repeat (2) @(negedge clk);
        check("rst_pos", {pos_x, pos_y}, 0);
        check("rst_facing", facing, 0);
        check("rst_pulses", {query_valid, moved, bump}, 0);
        rst_n = 1'b1;

        // 1: reset asserted in the middle of a query
        enable = 1'b1;
        @(negedge clk);
        load_dir(DIR_DOWN);
        send_ticks(4);
        wait_query();
        check("t1_query", {query_x, query_y}, {5'd0, 5'd1});
        #2 rst_n = 1'b0;
        #1;
        check("t1_qv_async", query_valid, 0);
        check("t1_pos", {pos_x, pos_y}, 0);
        check("t1_facing", facing, 0);
        @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);

        // 2: free move right with a 3-cycle ack delay
        do_step(1, DIR_RIGHT, 0, 3, 1, 0, 1, 0);

        // walk to (5,5)
        for (int i = 2; i <= 5; i++) do_step(1, DIR_RIGHT, 0, 0, i, 0, i, 0);
        for (int i = 1; i <= 5; i++) do_step(1, DIR_DOWN, 0, 0, 5, i, 5, i);

        // 3: wall below (5,5)
        do_step(1, DIR_DOWN, 1, 1, 5, 6, 5, 5);

        // walk to (10,10)
        for (int i = 6; i <= 10; i++) do_step(1, DIR_RIGHT, 0, 0, i, 5, i, 5);
        for (int i = 6; i <= 10; i++) do_step(1, DIR_DOWN, 0, 0, 10, i, 10, i);

        // 5: direction change while the left step is in flight
        load_dir(DIR_LEFT);
        send_ticks(4);
        wait_query();
        check("t5_query", {query_x, query_y}, {5'd9, 5'd10});
        char_dir  = DIR_DOWN;
        dir_valid = 1'b1;
        @(negedge clk);
        dir_valid = 1'b0;
        check("t5_facing", facing, 1);
        check("t5_query_held", {query_valid, query_x, query_y}, {1'b1, 5'd9, 5'd10});
        ack(0, 0);
        check_commit(1, 0, 9, 10);
        do_step(0, DIR_DOWN, 0, 0, 9, 11, 9, 11);

        // walk to (31,3)
        for (int i = 1; i <= 8; i++) do_step(1, DIR_UP, 0, 0, 9, 11 - i, 9, 11 - i);
        for (int i = 1; i <= 22; i++) do_step(1, DIR_RIGHT, 0, 0, 9 + i, 3, 9 + i, 3);

        // 4: right edge, then top edge
        load_dir(DIR_RIGHT);
        send_ticks(4);
        check("t4r_bump", bump, 1);
        check("t4r_moved", moved, 0);
        check("t4r_qv", query_valid, 0);
        check("t4r_pos", {pos_x, pos_y}, {5'd31, 5'd3});
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            check("t4r_quiet", {query_valid, bump, moved}, 0);
        end
        for (int i = 1; i <= 3; i++) do_step(1, DIR_UP, 0, 0, 31, 3 - i, 31, 3 - i);
        load_dir(DIR_UP);
        send_ticks(4);
        check("t4u_bump", bump, 1);
        check("t4u_moved", moved, 0);
        check("t4u_qv", query_valid, 0);
        check("t4u_pos", {pos_x, pos_y}, {5'd31, 5'd0});
        @(negedge clk);
        check("t4u_quiet", {query_valid, bump, moved}, 0);

        // 6: enable drops mid-query; ticks during the query are ignored
        load_dir(DIR_LEFT);
        send_ticks(4);
        wait_query();
        check("t6_query", {query_x, query_y}, {5'd30, 5'd0});
        enable = 1'b0;
        send_ticks(2);
        check("t6_not_aborted", query_valid, 1);
        ack(0, 0);
        check_commit(0, 0, 31, 0);
        send_ticks(4);
        check("t6_idle_qv", query_valid, 0);
        enable = 1'b1;
        @(negedge clk);
        send_ticks(3);
        check("t6_count_restart", query_valid, 0);
        do_step(0, DIR_LEFT, 0, 0, 30, 0, 30, 0);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
